// File: rtl/spike_dispatcher.sv
// spike_dispatcher: buffers spike addresses in a FIFO and issues them to the MAC stage, one per cycle, between timestep clear pulses.
// Optional macro SPIKE_DISP_DROP_CNT_EN enables the saturating drop counter.
module spike_dispatcher #(
    parameter int ADDR_BITS = 12,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMESTEP_CYCLES = 4,
    parameter logic [ADDR_BITS-1:0] IDLE_ADDR = '1
) (
    input  logic                          CLK_Disp,
    input  logic                          RST_Disp,
    input  logic                          in_valid,
    input  logic [ADDR_BITS-1:0]          in_addr,
    output logic                          in_ready,
    output logic [ADDR_BITS-1:0]          source_address,
    output logic                          addr_valid,
    output logic                          clear,
    output logic [15:0]                   timestep,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [7:0]                    drop_count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(TIMESTEP_CYCLES);
    localparam logic [PW:0] DEPTH = FIFO_DEPTH[PW:0];
    localparam logic [CW-1:0] LAST = CW'(TIMESTEP_CYCLES - 1);
    logic [ADDR_BITS-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] cyc;
    logic push, pop, clear_edge;
    logic [ADDR_BITS-1:0] head;
    assign in_ready   = fifo_count < DEPTH;
    assign push       = in_valid && in_ready;
    assign clear_edge = cyc == LAST;
    assign head       = mem[rd_ptr];
    // Never issue on a clear edge, and insert an idle cycle between identical back-to-back addresses.
    assign pop = (fifo_count != '0) && !clear_edge && !(addr_valid && head == source_address);
    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge CLK_Disp) begin
        if (push) mem[wr_ptr] <= in_addr;
    end
    // Timestep sequencing, FIFO bookkeeping and the registered issue port.
    always_ff @(posedge CLK_Disp) begin
        if (RST_Disp) begin
            cyc            <= '0;
            clear          <= 1'b0;
            timestep       <= '0;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            fifo_count     <= '0;
            addr_valid     <= 1'b0;
            source_address <= IDLE_ADDR;
        end else begin
            cyc            <= clear_edge ? '0 : cyc + 1'b1;
            clear          <= clear_edge;
            timestep       <= timestep + 16'(clear_edge);
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            fifo_count     <= fifo_count + (PW+1)'(push) - (PW+1)'(pop);
            addr_valid     <= pop;
            source_address <= pop ? head : IDLE_ADDR;
        end
    end
`ifdef SPIKE_DISP_DROP_CNT_EN
    // Count refused pushes, saturating so the value never wraps back to small numbers.
    always_ff @(posedge CLK_Disp) begin
        if (RST_Disp) drop_count <= '0;
        else if (in_valid && !in_ready && drop_count != 8'hFF) drop_count <= drop_count + 1'b1;
    end
`else
    assign drop_count = '0;
`endif
endmodule
